// File: rtl/boot_loader.sv
// Byte-stream image loader: 16-bit little-endian word count header, then LE 32-bit words into imem.
// Latency: one cycle from a word's fourth accepted byte to its imem_we pulse; done one cycle after the last write.
// Backpressure: in_ready drops during the write cycle and in DONE/ERR; in_valid gaps simply stall the loader.
module boot_loader #(
    parameter int MEM_WORDS = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              start,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst_n,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        HDR0  = 3'd0,
        HDR1  = 3'd1,
        LOAD  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_t;

    // One extra index bit so a full-depth image can count up to MEM_WORDS.
    localparam logic [ADDR_W:0] IDX_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [16:0]     MEM_LIMIT = 17'(MEM_WORDS);

    state_t          state;
    logic [15:0]     count;
    logic [ADDR_W:0] idx;
    logic [1:0]      byte_cnt;
    logic [31:0]     word;

    logic            accept;
    logic [15:0]     hdr_count;
    logic [ADDR_W:0] idx_inc;
    logic            hdr_bad;

    assign accept     = in_valid & in_ready;
    // Full header as it will look once the high byte lands this cycle.
    assign hdr_count  = {in_data, count[7:0]};
    assign hdr_bad    = (hdr_count == 16'd0) || ({1'b0, hdr_count} > MEM_LIMIT);
    assign idx_inc    = idx + IDX_ONE;
    // The count check bounds idx below MEM_WORDS whenever a write is issued.
    assign imem_addr  = idx[ADDR_W-1:0];
    assign imem_wdata = word;

    // Loader FSM; every output is registered and updated alongside the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= HDR0;
            count      <= '0;
            idx        <= '0;
            byte_cnt   <= '0;
            word       <= '0;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            core_rst_n <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                HDR0: begin
                    // in_ready comes up on the first edge after reset release.
                    in_ready <= 1'b1;
                    if (accept) begin
                        count[7:0] <= in_data;
                        state      <= HDR1;
                    end
                end
                HDR1: begin
                    if (accept) begin
                        count[15:8] <= in_data;
                        if (hdr_bad) begin
                            state    <= ERR;
                            in_ready <= 1'b0;
                            error    <= 1'b1;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        word[{byte_cnt, 3'b000} +: 8] <= in_data;
                        byte_cnt                      <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state    <= WRITE;
                            in_ready <= 1'b0;
                            imem_we  <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    idx <= idx_inc;
                    if (16'(idx_inc) == count) begin
                        state      <= DONE;
                        done       <= 1'b1;
                        core_rst_n <= 1'b1;
                    end else begin
                        state    <= LOAD;
                        in_ready <= 1'b1;
                    end
                end
                DONE, ERR: begin
                    // Terminal states hold until a re-arm request.
                    if (start) begin
                        state      <= HDR0;
                        idx        <= '0;
                        byte_cnt   <= '0;
                        count      <= '0;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        core_rst_n <= 1'b0;
                        in_ready   <= 1'b1;
                    end
                end
                default: begin
                    state    <= HDR0;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: scoreboard of expected imem writes,
// popped and compared as the DUT pulses imem_we.
// Covers back-to-back and gapped streams, header rejects, full depth, mid-load reset and re-arm.
module tb_boot_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        start;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst_n;
    logic        done;
    logic        error;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int last_we_cyc = 0;
    int done_rise_cyc = 0;
    int last_addr   = 0;
    logic prev_done = 1'b0;

    int          exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] img[$];

    boot_loader #(.MEM_WORDS(1024), .ADDR_W(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .start      (start),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst_n (core_rst_n),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write monitor: pops the scoreboard on every imem_we pulse.
    always @(negedge clk) begin
        cyc++;
        if (reset === 1'b1 && imem_we === 1'b1) begin
            last_we_cyc = cyc;
            last_addr   = int'(imem_addr);
            check("core_held_during_write", core_rst_n, 0);
            if (exp_addr.size() == 0) begin
                check("unexpected_we", 1, 0);
            end else begin
                check("wr_addr", imem_addr, exp_addr.pop_front());
                check("wr_data", imem_wdata, exp_data.pop_front());
            end
        end
        if (done === 1'b1 && prev_done !== 1'b1) done_rise_cyc = cyc;
        prev_done = done;
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Sends header n and img[0..n-1] LE; stop_after>0 truncates the payload.
    task automatic load_image(input int n, input int gap, input int stop_after, input bit start_in_load);
        int sent = 0;
        logic [31:0] cur;
        logic [15:0] hdr;
        hdr = 16'(n);
        send_byte(hdr[7:0], gap);
        send_byte(hdr[15:8], gap);
        for (int w = 0; w < n; w++) begin
            cur = img[w];
            for (int k = 0; k < 4; k++) begin
                if (stop_after > 0 && sent >= stop_after) return;
                if (k == 0 && (stop_after == 0 || sent + 4 <= stop_after)) begin
                    exp_addr.push_back(w);
                    exp_data.push_back(cur);
                end
                if (start_in_load && w == 0 && k == 2) pulse_start();
                send_byte(cur[8*k +: 8], gap);
                sent++;
            end
        end
    endtask

    task automatic wait_done();
        int t = 0;
        while (done !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        #1;
        check("done_seen", done, 1);
        check("core_released", core_rst_n, 1);
        check("done_latency", done_rise_cyc - last_we_cyc, 1);
        check("sb_drained", exp_addr.size(), 0);
    endtask

    task automatic check_err_state(input string tag);
        @(negedge clk);
        check({tag, "_error"}, error, 1);
        check({tag, "_ready"}, in_ready, 0);
        check({tag, "_core_rst"}, core_rst_n, 0);
        check({tag, "_done"}, done, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        start    = 1'b0;

        // Reset values while reset is held low.
        #12;
        check("rst_ready", in_ready, 0);
        check("rst_we", imem_we, 0);
        check("rst_core", core_rst_n, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("ready_after_rst", in_ready, 1);

        // Two-word reference image, back-to-back.
        img = {};
        img.push_back(32'h03208093);
        img.push_back(32'h01410113);
        load_image(2, 0, 0, 1'b0);
        wait_done();
        check("done_ready_low", in_ready, 0);

        // Same image with in_valid toggling every other cycle.
        pulse_start();
        load_image(2, 1, 0, 1'b0);
        wait_done();

        // Zero-length header is rejected and sticky until start.
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check_err_state("hdr0");
        repeat (5) @(negedge clk);
        check("err_sticky", error, 1);
        pulse_start();
        @(negedge clk);
        check("rearm_error", error, 0);
        check("rearm_ready", in_ready, 1);

        // 1025 words exceeds depth.
        send_byte(8'h01, 0);
        send_byte(8'h04, 0);
        check_err_state("hdr1025");
        pulse_start();

        // Full depth: 1024 words, last at 1023.
        img = {};
        for (int i = 0; i < 1024; i++) img.push_back($urandom);
        load_image(1024, 0, 0, 1'b0);
        wait_done();
        check("last_addr", last_addr, 1023);

        // Reset mid-load after 5 payload bytes.
        pulse_start();
        img = {};
        for (int i = 0; i < 3; i++) img.push_back($urandom);
        load_image(3, 0, 5, 1'b0);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_ready", in_ready, 0);
        check("midrst_we", imem_we, 0);
        check("midrst_core", core_rst_n, 0);
        check("midrst_done", done, 0);
        check("midrst_error", error, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_sb", exp_addr.size(), 0);
        load_image(3, 0, 0, 1'b0);
        wait_done();

        // start during LOAD is ignored; start in DONE re-arms and reloads from 0.
        pulse_start();
        img = {};
        for (int i = 0; i < 2; i++) img.push_back($urandom);
        load_image(2, 0, 0, 1'b1);
        wait_done();
        pulse_start();
        @(negedge clk);
        check("rearm_core_low", core_rst_n, 0);
        check("rearm_done_low", done, 0);
        img = {};
        for (int i = 0; i < 4; i++) img.push_back($urandom);
        load_image(4, 0, 0, 1'b0);
        wait_done();

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
